// File: rtl/u_axil_reg_slave.sv
// u_axil_reg_slave: AXI4-Lite slave exposing 16 word registers.
//   0..13 read/write (driven on REG_OUT, strobed on WR_PULSE),
//   14 read-only live STATUS_IN, 15 read-only C_ID.
// Optional feature macro: AXIL_SLV_WSTRB_EN (byte-strobe merging on writes;
// when undefined the full word is written and WSTRB is ignored).
//
// Handshake semantics: a transfer on any channel happens on the rising edge
// where VALID and READY are both high; VALID/payload are held by the source
// until then. AW and W each land in a one-entry holding slot; the write
// commits on the edge at which both slots are (or become) full, which is also
// the edge that raises BVALID. No new AW/W is taken while BVALID is high.
`timescale 1ns/1ps
module u_axil_reg_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] C_ID               = 32'h0A55_0001
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     STATUS_IN,
    output logic [14*C_S_AXI_DATA_WIDTH-1:0]  REG_OUT,
    output logic [13:0]                       WR_PULSE
);
    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int SW   = DW / 8;
    localparam int NREG = 14;
    localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

    // Registered state
    logic          r_init;
    logic          r_aw_full;
    logic [3:0]    r_aw_idx;
    logic          r_w_full;
    logic [DW-1:0] r_w_data;
    logic [SW-1:0] r_w_strb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic [13:0]   r_wr_pulse;
    logic [DW-1:0] r_regs [0:NREG-1];
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    // Combinational helpers
    logic          w_awready;
    logic          w_wready;
    logic          w_arready;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_commit;
    logic [3:0]    w_cm_idx;
    logic [DW-1:0] w_cm_data;
    logic [SW-1:0] w_cm_strb;
    logic          w_cm_ok;
    logic [DW-1:0] w_wr_word;
    logic [3:0]    w_ar_idx;
    logic [DW-1:0] w_rd_sel;
    logic          w_unused;

    // Readies stay low until the first edge after reset release (r_init).
    assign w_awready = r_init & ~r_aw_full & ~r_bvalid;
    assign w_wready  = r_init & ~r_w_full  & ~r_bvalid;
    assign w_arready = r_init & ~r_rvalid;

    assign w_aw_hs  = S_AXI_AWVALID & w_awready;
    assign w_w_hs   = S_AXI_WVALID  & w_wready;
    assign w_ar_hs  = S_AXI_ARVALID & w_arready;

    // Commit as soon as both halves are available, held or arriving now.
    assign w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    assign w_cm_idx  = r_aw_full ? r_aw_idx : S_AXI_AWADDR[5:2];
    assign w_cm_data = r_w_full  ? r_w_data : S_AXI_WDATA;
    assign w_cm_strb = r_w_full  ? r_w_strb : S_AXI_WSTRB;
    assign w_cm_ok   = (w_cm_idx < 4'd14);
    assign w_ar_idx  = S_AXI_ARADDR[5:2];

`ifdef AXIL_SLV_WSTRB_EN
    logic [DW-1:0] w_cm_old;

    // Current contents of the write target, base for the byte merge.
    always_comb begin
        w_cm_old = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_cm_idx == 4'(i)) w_cm_old = r_regs[i];
        end
    end

    // Replace only the strobed bytes.
    always_comb begin
        w_wr_word = w_cm_old;
        for (int b = 0; b < SW; b++) begin
            if (w_cm_strb[b]) w_wr_word[8*b +: 8] = w_cm_data[8*b +: 8];
        end
    end
`else
    assign w_wr_word = w_cm_data;
`endif

    // Read mux: RW bank, live status, constant ID.
    always_comb begin
        w_rd_sel = '0;
        if (w_ar_idx == 4'd15) begin
            w_rd_sel = DW'(C_ID);
        end else if (w_ar_idx == 4'd14) begin
            w_rd_sel = STATUS_IN;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_ar_idx == 4'(i)) w_rd_sel = r_regs[i];
            end
        end
    end

    // Marks the first edge after reset release; gates all readies.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_init <= 1'b0;
        else                r_init <= 1'b1;
    end

    // AW/W holding slots: fill on handshake, empty on commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[5:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
        end
    end

    // Write response: raised at commit, held until accepted.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_cm_ok ? 2'b00 : 2'b10;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Per-register strobe, aligned with the first BVALID cycle.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)            r_wr_pulse <= '0;
        else if (w_commit && w_cm_ok)  r_wr_pulse <= ONE_HOT0 << w_cm_idx;
        else                           r_wr_pulse <= '0;
    end

    // Read/write register bank; read-only indices never update.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_commit && w_cm_ok && (w_cm_idx == 4'(i))) r_regs[i] <= w_wr_word;
            end
        end
    end

    // Read data: captured at the AR handshake (pre-write value), held until taken.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_sel;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_reg_out
            assign REG_OUT[g*DW +: DW] = r_regs[g];
        end
    endgenerate

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign WR_PULSE      = r_wr_pulse;

    // Address byte-offset bits, PROT fields and (in full-word mode) strobes carry no meaning here.
    assign w_unused = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        S_AXI_AWPROT, S_AXI_ARPROT, w_cm_strb};

endmodule

// File: tb/tb_u_axil_reg_slave.sv
// Testbench for u_axil_reg_slave: directed vector table plus hand-written
// sequences for back-pressure, same-edge read/write, and reset corner cases.
`timescale 1ns/1ps
module tb_u_axil_reg_slave;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata, status_in;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [447:0] reg_out;
    logic [13:0]  wr_pulse;

    u_axil_reg_slave dut (
        .S_AXI_ACLK(clk),        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),   .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),     .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),   .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
        .STATUS_IN(status_in),   .REG_OUT(reg_out),
        .WR_PULSE(wr_pulse)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] model [0:13];
    logic [31:0] exp_q [$];

    function automatic logic [447:0] packed_model();
        logic [447:0] v;
        for (int i = 0; i < 14; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [13:0] pulse,
                            output int lat, output bit early_ready, output bit ok);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        bit aw_will = 1'b0;
        bit w_will  = 1'b0;
        int c = 0;
        ok = 1'b0; early_ready = 1'b0; resp = '0; pulse = '0; lat = 0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        while (!ok && c < 50) begin
            @(negedge clk);
            if (aw_will) aw_pend = 1'b0;
            if (w_will)  w_pend  = 1'b0;
            if (bvalid) begin
                ok = 1'b1; resp = bresp; pulse = wr_pulse; lat = c;
            end else begin
                if ((!aw_pend && awready) || (!w_pend && wready)) early_ready = 1'b1;
                awvalid = aw_pend && (c >= aw_dly);
                wvalid  = w_pend  && (c >= w_dly);
                aw_will = awvalid && awready;
                w_will  = wvalid && wready;
                c++;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit ok);
        bit ar_pend = 1'b1;
        bit ar_will = 1'b0;
        int c = 0;
        ok = 1'b0; data = '0; resp = '0; lat = 0;
        araddr = addr; rready = 1'b1;
        while (!ok && c < 50) begin
            @(negedge clk);
            if (ar_will) ar_pend = 1'b0;
            if (rvalid) begin
                ok = 1'b1; data = rdata; resp = rresp; lat = c;
            end else begin
                arvalid = ar_pend;
                ar_will = arvalid && arready;
                c++;
            end
        end
        arvalid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [13:0] exp_pulse;
        int          exp_lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];
    logic [31:0] strb_exp;

    initial begin
        logic [1:0]  resp;
        logic [13:0] pulse;
        logic [31:0] data;
        int lat;
        bit early, ok;

`ifdef AXIL_SLV_WSTRB_EN
        strb_exp = 32'hFF00_FF00;
`else
        strb_exp = 32'h0000_0000;
`endif
        //            wr   addr   data          strb aw w  exp_data      resp   pulse     lat
        vec[0]  = '{1'b1, 6'h04, 32'h1234_5678, 4'hF, 0, 0, 32'h1234_5678, 2'b00, 14'h0002, 1};
        vec[1]  = '{1'b1, 6'h08, 32'hCAFE_0000, 4'hF, 3, 0, 32'hCAFE_0000, 2'b00, 14'h0004, 4};
        vec[2]  = '{1'b0, 6'h04, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00, 14'h0000, 1};
        vec[3]  = '{1'b0, 6'h08, 32'h0,         4'h0, 0, 0, 32'hCAFE_0000, 2'b00, 14'h0000, 1};
        vec[4]  = '{1'b1, 6'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,         2'b10, 14'h0000, 1};
        vec[5]  = '{1'b0, 6'h3C, 32'h0,         4'h0, 0, 0, 32'h0A55_0001, 2'b00, 14'h0000, 1};
        vec[6]  = '{1'b1, 6'h38, 32'h0000_1111, 4'hF, 0, 0, 32'h0,         2'b10, 14'h0000, 1};
        vec[7]  = '{1'b0, 6'h38, 32'h0,         4'h0, 0, 0, 32'h5A5A_A5A5, 2'b00, 14'h0000, 1};
        vec[8]  = '{1'b1, 6'h00, 32'hFFFF_FFFF, 4'hF, 0, 2, 32'hFFFF_FFFF, 2'b00, 14'h0001, 3};
        vec[9]  = '{1'b1, 6'h03, 32'h0000_0000, 4'h5, 0, 0, strb_exp,      2'b00, 14'h0001, 1};
        vec[10] = '{1'b0, 6'h00, 32'h0,         4'h0, 0, 0, strb_exp,      2'b00, 14'h0000, 1};
        vec[11] = '{1'b1, 6'h34, 32'hA5A5_0013, 4'hF, 1, 1, 32'hA5A5_0013, 2'b00, 14'h2000, 2};
        vec[12] = '{1'b0, 6'h37, 32'h0,         4'h0, 0, 0, 32'hA5A5_0013, 2'b00, 14'h0000, 1};
        vec[13] = '{1'b0, 6'h0C, 32'h0,         4'h0, 0, 0, 32'h0000_0000, 2'b00, 14'h0000, 1};

        for (int i = 0; i < 14; i++) model[i] = '0;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        status_in = 32'h5A5A_A5A5;

        // ---- reset state ----
        #2;
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rdata",   rdata,   32'h0);
        chk("rst_reg_out", reg_out, 448'h0);
        chk("rst_pulse",   wr_pulse, 14'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_arready_before_edge", arready, 1'b0);
        @(negedge clk);
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready",  wready,  1'b1);
        chk("rel_arready", arready, 1'b1);

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            if (vec[i].wr) begin
                do_write(vec[i].addr, vec[i].data, vec[i].strb, vec[i].aw_dly, vec[i].w_dly,
                         resp, pulse, lat, early, ok);
                chk($sformatf("v%0d_wr_done", i), ok, 1'b1);
                chk($sformatf("v%0d_bresp", i), resp, vec[i].exp_resp);
                chk($sformatf("v%0d_pulse", i), pulse, vec[i].exp_pulse);
                chk($sformatf("v%0d_blat", i), lat, vec[i].exp_lat);
                chk($sformatf("v%0d_ready_low_while_held", i), early, 1'b0);
                if (vec[i].addr[5:2] < 4'd14) model[vec[i].addr[5:2]] = vec[i].exp_data;
                chk($sformatf("v%0d_reg_out", i), reg_out, packed_model());
                @(negedge clk);
                chk($sformatf("v%0d_bvalid_clear", i), bvalid, 1'b0);
                chk($sformatf("v%0d_pulse_clear", i), wr_pulse, 14'h0);
            end else begin
                exp_q.push_back(vec[i].exp_data);
                do_read(vec[i].addr, data, resp, lat, ok);
                chk($sformatf("v%0d_rd_done", i), ok, 1'b1);
                chk($sformatf("v%0d_rdata", i), data, exp_q.pop_front());
                chk($sformatf("v%0d_rresp", i), resp, vec[i].exp_resp);
                chk($sformatf("v%0d_rlat", i), lat, vec[i].exp_lat);
                @(negedge clk);
                chk($sformatf("v%0d_rvalid_clear", i), rvalid, 1'b0);
                chk($sformatf("v%0d_arready_back", i), arready, 1'b1);
            end
        end

        // ---- B back-pressure ----
        @(negedge clk);
        awaddr = 6'h14; wdata = 32'h0000_0055; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_bvalid", k),  bvalid,  1'b1);
            chk($sformatf("bp%0d_awready", k), awready, 1'b0);
            chk($sformatf("bp%0d_wready", k),  wready,  1'b0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("bp_bvalid_clear", bvalid, 1'b0);
        chk("bp_awready_back", awready, 1'b1);
        model[5] = 32'h0000_0055;
        chk("bp_reg_out", reg_out, packed_model());

        // ---- R back-pressure; STATUS_IN sampled at AR edge ----
        araddr = 6'h38; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; status_in = 32'h0000_1234;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rp%0d_rvalid", k),  rvalid,  1'b1);
            chk($sformatf("rp%0d_rdata", k),   rdata,   32'h5A5A_A5A5);
            chk($sformatf("rp%0d_arready", k), arready, 1'b0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("rp_rvalid_clear", rvalid, 1'b0);
        chk("rp_arready_back", arready, 1'b1);
        status_in = 32'h5A5A_A5A5;

        // ---- read and write on the same edge to the same register ----
        awaddr = 6'h18; wdata = 32'h0000_0066; wstrb = 4'hF; araddr = 6'h18;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[6] = 32'h0000_0066;
        chk("rw_rvalid", rvalid, 1'b1);
        chk("rw_rdata_old", rdata, 32'h0);
        chk("rw_bvalid", bvalid, 1'b1);
        chk("rw_reg_out", reg_out, packed_model());
        rready = 1'b1;
        @(negedge clk);

        // ---- reset while BVALID is high ----
        awaddr = 6'h1C; wdata = 32'h0000_0077; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rb_bvalid_pre", bvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) model[i] = '0;
        chk("rb_bvalid", bvalid, 1'b0);
        chk("rb_reg_out", reg_out, packed_model());
        chk("rb_pulse", wr_pulse, 14'h0);
        chk("rb_arready", arready, 1'b0);
        chk("rb_awready", awready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; bready = 1'b1;
        #1;
        chk("rb_arready_before_edge", arready, 1'b0);
        @(negedge clk);
        chk("rb_arready_after", arready, 1'b1);
        chk("rb_awready_after", awready, 1'b1);
        chk("rb_wready_after", wready, 1'b1);

        // ---- held W entry discarded by reset ----
        wdata = 32'h0000_0099; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        awaddr = 6'h04; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        chk("disc_no_bvalid", bvalid, 1'b0);
        chk("disc_reg_out", reg_out, packed_model());
        chk("disc_wready", wready, 1'b1);
        wdata = 32'h0000_0077; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        model[1] = 32'h0000_0077;
        chk("disc_late_w_bvalid", bvalid, 1'b1);
        chk("disc_late_w_pulse", wr_pulse, 14'h0002);
        chk("disc_late_w_reg_out", reg_out, packed_model());
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/u_axil_reg_slave.md
U_AXIL_REG_SLAVE -- requirements
Module: u_axil_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width (16 word registers).
REQ-003 SHALL have parameter C_ID, default 32'h0A55_0001, constant value returned by register 15.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: S_AXI_ACLK, S_AXI_ARESETN.
REQ-005 Ports, each `name  direction  width  meaning`:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  async active-low reset.
- S_AXI_AWADDR  in  6  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  response valid.
- S_AXI_BREADY  in  1  response ready.
- S_AXI_ARADDR  in  6  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read valid.
- S_AXI_RREADY  in  1  read ready.
- STATUS_IN  in  32  live value read at register 14.
- REG_OUT  out  448  registers 0..13, reg i at bits [32i+31:32i].
- WR_PULSE  out  14  one-cycle strobe per written register 0..13.

Function
REQ-006 Register index SHALL be ADDR[5:2]; ADDR[1:0] ignored.
REQ-007 Registers 0..13 SHALL be read/write; 14 read-only returns STATUS_IN; 15 read-only returns C_ID.
REQ-008 AW and W channels SHALL be accepted independently, in either order or the same cycle, each into a one-entry holding register.
REQ-009 AWREADY SHALL be high iff the AW holding entry is empty and BVALID is low; WREADY likewise for the W entry.
REQ-010 On the first clock edge where both entries are full, SHALL commit the write, set BVALID=1, and clear both entries.
REQ-011 Write response rules:
- Commit to index 0..13: BRESP=2'b00.
- Commit to index 14/15: no state change, no WR_PULSE, BRESP=2'b10 (SLVERR).
REQ-012 BVALID/BRESP SHALL hold until the BVALID&BREADY edge; no new AW/W accepted while BVALID=1.
REQ-013 WR_PULSE[i] SHALL be high exactly one cycle, coincident with the first BVALID cycle, for a committed write to register i.
REQ-014 ARREADY SHALL equal !RVALID.
REQ-015 On an AR handshake edge, SHALL register RDATA (selected register) and set RVALID=1 with RRESP=2'b00; read latency is 1 cycle.
REQ-016 RDATA/RVALID SHALL hold until the RVALID&RREADY edge; back-to-back reads therefore sustain one per two cycles.
REQ-017 A read and a write committing on the same edge to the same register SHALL return the pre-write value.
REQ-018 STATUS_IN SHALL be sampled at the AR handshake edge.

Reset
REQ-019 While S_AXI_ARESETN=0, asynchronously and immediately:
- AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
- BRESP, RRESP, RDATA = 0; REG_OUT = 0; WR_PULSE = 0; holding entries empty.
REQ-020 Reset mid-transaction SHALL discard pending AW/W/B/R state with no register update.
REQ-021 On the first edge after deassertion, SHALL raise AWREADY, WREADY, ARREADY to 1.

Configuration
REQ-022 Macro AXIL_SLV_WSTRB_EN:
- Defined: only bytes with WSTRB[b]=1 are updated.
- Undefined: WSTRB is ignored and the full 32-bit word is written.

Verification
REQ-023 AW 0x04 and W 0x1234_5678 (WSTRB=F) in the same cycle, BREADY=1 -> BVALID the next cycle, BRESP=00, REG_OUT[63:32]=0x1234_5678, WR_PULSE=14'h0002 for one cycle.
REQ-024 W 0xCAFE_0000 three cycles before AW 0x08 -> WREADY low after acceptance, commit edge follows the AW handshake, REG_OUT reg2=0xCAFE_0000.
REQ-025 Write 0x3C (reg 15) -> BRESP=10, WR_PULSE=0; then read 0x3C -> RDATA=0x0A55_0001, RRESP=00.
REQ-026 With AXIL_SLV_WSTRB_EN: reg0=0xFFFF_FFFF, then write 0 with WSTRB=4'b0101 -> reg0=0xFF00_FF00; without the macro -> reg0=0.
REQ-027 Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0; RREADY=0 -> RDATA stable, ARREADY=0.
REQ-028 Assert reset while BVALID=1 -> BVALID=0 immediately, REG_OUT=0, ARREADY returns to 1 on the first edge after release.
